// File: rtl/signed_booth_mult_ctrl.sv
// Sequential radix-2 Booth signed multiplier core.
// It holds the operand registers, the accumulator datapath and the control FSM
// for an N x M two's-complement multiply. One add/sub-and-shift step runs per clock.
// The external 4-bit iteration counter is enabled by cnt, and it returns the
// last-iteration flag k. An internal shadow index itr cross-checks that flag.
//
// Handshake: start is sampled only while idle; busy is high from the cycle
// after an accepted start through the done cycle; done pulses for one cycle
// with product already updated; requests while busy are dropped, not queued.
module signed_booth_mult_ctrl #(
   parameter int N = 8,
   parameter int M = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     multiplicand,
   input  logic [M-1:0]     multiplier,
   input  logic             k,
   output logic             cnt,
   output logic             busy,
   output logic             done,
   output logic [N+M-1:0]   product,
   output logic             err
);

   localparam int            IW       = $clog2(M);
   localparam logic [IW-1:0] ITR_LAST = IW'(M - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [N:0]       mreg_q;     // sign-extended multiplicand
   logic [N:0]       a_q;        // accumulator, one guard bit for -2^(N-1)
   logic [M-1:0]     q_q;        // multiplier / low product half
   logic             q1_q;       // Booth look-behind bit
   logic [IW-1:0]    itr_q;      // shadow iteration index
   logic [N+M-1:0]   product_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic [N:0]       a_sum;
   logic [N:0]       a_d;
   logic [M-1:0]     q_d;
   logic             q1_d;
   logic [IW-1:0]    itr_d;
   logic             last_step;
   logic             step_err;

   // One Booth step: conditional add/sub of Mreg, then arithmetic shift of {A,Q,q_1}
   always_comb begin
      a_sum = a_q;
      case ({q_q[0], q1_q})
         2'b01:   a_sum = a_q + mreg_q;
         2'b10:   a_sum = a_q - mreg_q;
         default: a_sum = a_q;
      endcase
      a_d       = {a_sum[N], a_sum[N:1]};
      q_d       = {a_sum[0], q_q[M-1:1]};
      q1_d      = q_q[0];
      itr_d     = itr_q + IW'(1);
      // Leave on whichever of the counter flag or the shadow index says "last".
      last_step = k | (itr_q == ITR_LAST);
      // The two must agree; any disagreement is a protocol error.
      step_err  = k ^ (itr_q == ITR_LAST);
   end

   // Control FSM with registered busy/done/product/err and the datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mreg_q    <= '0;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         itr_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mreg_q  <= {multiplicand[N-1], multiplicand};
                  a_q     <= '0;
                  q_q     <= multiplier;
                  q1_q    <= 1'b0;
                  itr_q   <= '0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               a_q   <= a_d;
               q_q   <= q_d;
               q1_q  <= q1_d;
               itr_q <= itr_d;
               if (step_err) begin
                  err_q <= 1'b1;
               end
               if (last_step) begin
                  // Capture the result of this final step so it is visible with done.
                  product_q <= {a_d[N-1:0], q_d};
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Counter enable is purely state-decoded so k cannot loop back into it
   always_comb begin
      cnt = (state_q == S_CALC);
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign err     = err_q;

endmodule

// File: tb/tb_signed_booth_mult_ctrl.sv
// Bench for signed_booth_mult_ctrl.
// It models the external 4-bit iteration counter and its registered k flag.
// A scoreboard expects each product from a signed-arithmetic reference model.
`timescale 1ns/1ps
module tb_signed_booth_mult_ctrl;

   localparam int N = 8;
   localparam int M = 16;
   localparam int W = N + M;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [M-1:0]   multiplier;
   logic           k;
   logic           cnt;
   logic           busy;
   logic           done;
   logic [W-1:0]   product;
   logic           err;

   int checks = 0;
   int errors = 0;

   // scoreboard
   logic [W-1:0]   exp_q[$];
   logic           exp_err_q[$];
   logic           exp_chk_q[$];
   int             exp_len_q[$];
   int             acc_hist[$];

   // counter model controls
   int  k_mode   = 0;   // 0: counter flag, 1: forced early k, 2: k suppressed
   int  force_at = 4;
   bit  ctr_clr  = 0;

   int  cyc = 0;

   signed_booth_mult_ctrl #(.N(N), .M(M)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .k            (k),
      .cnt          (cnt),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .err          (err)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_mul(input logic [N-1:0] a, input logic [M-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[W-1:0];
   endfunction

   // iteration counter model: 4-bit up counter enabled by cnt, flag registered
   // one cycle after the count reaches M-2; k driven at negedge
   initial begin
      int  ctr_now;
      int  ctr_nxt;
      bit  k_pend;
      k       = 1'b0;
      ctr_nxt = 0;
      k_pend  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || ctr_clr) begin
            ctr_nxt = 0;
            k_pend  = 1'b0;
         end
         ctr_now = ctr_nxt;
         case (k_mode)
            0:       k = k_pend;
            1:       k = cnt && (ctr_now == force_at);
            default: k = 1'b0;
         endcase
         k_pend  = cnt && (ctr_now == M - 2);
         ctr_nxt = cnt ? (ctr_now + 1) % M : ctr_now;
      end
   end

   // monitor: samples 1ns after each rising edge, pops the scoreboard on done
   initial begin
      bit prev_busy;
      int acc_cyc;
      int cnt_run;
      logic [W-1:0] ep;
      logic ee;
      logic ec;
      int el;
      prev_busy = 1'b0;
      acc_cyc   = 0;
      cnt_run   = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!rst_n) begin
            prev_busy = 1'b0;
            cnt_run   = 0;
            continue;
         end
         if (busy && !prev_busy) begin
            acc_cyc = cyc;
            acc_hist.push_back(cyc);
         end
         if (cnt) cnt_run++;
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'(0));
            end else begin
               ep = exp_q.pop_front();
               ee = exp_err_q.pop_front();
               ec = exp_chk_q.pop_front();
               el = exp_len_q.pop_front();
               if (ec) chk("product", 64'(product), 64'(ep));
               chk("err_at_done", 64'(err), 64'(ee));
               chk("latency", 64'(cyc - acc_cyc), 64'(el));
               chk("cnt_len", 64'(cnt_run), 64'(el));
            end
            cnt_run = 0;
         end
         prev_busy = busy;
      end
   end

   // driver: waits for idle, presents one request, pushes its expectation
   task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b, input bit hold,
                        input logic exp_e, input logic exp_c, input int len);
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) chk("issue_timeout", 64'(busy), 64'(0));
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      exp_q.push_back(ref_mul(a, b));
      exp_err_q.push_back(exp_e);
      exp_chk_q.push_back(exp_c);
      exp_len_q.push_back(len);
      @(posedge clk);
      if (!hold) begin
         #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
   endtask

   task automatic clear_ctr();
      ctr_clr = 1'b1;
      repeat (2) @(negedge clk);
      ctr_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] da [5];
      logic [M-1:0] db [5];
      int guard;
      da[0] = 8'd3;    db[0] = 16'd5;
      da[1] = 8'h80;   db[1] = 16'h8000;
      da[2] = 8'h7F;   db[2] = 16'hFFFF;
      da[3] = 8'h00;   db[3] = 16'h8000;
      da[4] = 8'h80;   db[4] = 16'h7FFF;

      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (M + 2) @(negedge clk);
      chk("rst_cnt",     64'(cnt),     64'(0));
      chk("rst_busy",    64'(busy),    64'(0));
      chk("rst_done",    64'(done),    64'(0));
      chk("rst_product", 64'(product), 64'(0));
      chk("rst_err",     64'(err),     64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // directed operand pairs, including both most-negative operands
      for (int i = 0; i < 5; i++) begin
         issue(da[i], db[i], 1'b0, 1'b0, 1'b1, M);
         wait_idle();
      end

      // start held high across three operations
      acc_hist.delete();
      issue(8'h15, 16'h1234, 1'b1, 1'b0, 1'b1, M);
      issue(8'hF0, 16'h8001, 1'b1, 1'b0, 1'b1, M);
      issue(8'h7F, 16'h7FFF, 1'b1, 1'b0, 1'b1, M);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      chk("held_starts", 64'(acc_hist.size()), 64'(3));
      if (acc_hist.size() == 3) begin
         chk("held_spacing1", 64'(acc_hist[1] - acc_hist[0]), 64'(M + 2));
         chk("held_spacing2", 64'(acc_hist[2] - acc_hist[1]), 64'(M + 2));
      end

      // reset in the 7th CALC cycle
      issue(8'd100, 16'd200, 1'b0, 1'b0, 1'b1, M);
      guard = 0;
      while (guard < 50) begin
         if (cnt) guard++;
         if (guard == 7) break;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_cnt",     64'(cnt),     64'(0));
      chk("midrst_busy",    64'(busy),    64'(0));
      chk("midrst_done",    64'(done),    64'(0));
      chk("midrst_product", 64'(product), 64'(0));
      exp_q.delete();
      exp_err_q.delete();
      exp_chk_q.delete();
      exp_len_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(8'd7, 16'hFFFD, 1'b0, 1'b0, 1'b1, M);
      wait_idle();

      // early k in the 5th CALC cycle
      k_mode   = 1;
      force_at = 4;
      issue(8'h5A, 16'h0F0F, 1'b0, 1'b1, 1'b0, 5);
      wait_idle();
      k_mode = 0;
      repeat (3) @(negedge clk);
      chk("err_sticky", 64'(err), 64'(1));
      clear_ctr();
      issue(8'h11, 16'h2222, 1'b0, 1'b0, 1'b1, M);
      #1;
      chk("err_cleared_on_start", 64'(err), 64'(0));
      wait_idle();

      // k never asserted: full 16 steps, error flagged, product still exact
      k_mode = 2;
      issue(8'hC3, 16'hA5A5, 1'b0, 1'b1, 1'b1, M);
      wait_idle();
      k_mode = 0;
      repeat (2) @(negedge clk);
      chk("err_sticky_nok", 64'(err), 64'(1));

      // random signed operand pairs
      for (int i = 0; i < 1000; i++) begin
         issue(N'($urandom), M'($urandom), 1'b0, 1'b0, 1'b1, M);
         wait_idle();
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
